// File: rtl/ik_swift_iter_ctrl.sv
// ik_swift_iter_ctrl: runs the ik_swift core until joint deltas fall below tolerance, the budget is spent, or the core stalls
// Host side: start/cfg_*/z_in/joint_type_in/dh_init/target_in job load, busy, result_valid/result_ack, dh_result, iter_count, converged, timeout_err
// Core side: core_en level, core_rst one-cycle clear per iteration, core_done/core_delta/core_dh_out results, core_z/core_joint_type/core_dh_in/core_target operands
module ik_swift_iter_ctrl #(
  parameter int W = 36,
  parameter int ITER_W = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ITER_W-1:0] cfg_max_iter,
  input  logic [W-1:0]      cfg_tol,
  input  logic [3*W-1:0]    z_in,
  input  logic [5:0]        joint_type_in,
  input  logic [6*W-1:0]    dh_init,
  input  logic [6*W-1:0]    target_in,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ack,
  output logic [6*W-1:0]    dh_result,
  output logic [ITER_W-1:0] iter_count,
  output logic              converged,
  output logic              timeout_err,
  output logic              core_en,
  output logic              core_rst,
  input  logic              core_done,
  input  logic [6*W-1:0]    core_delta,
  input  logic [6*W-1:0]    core_dh_out,
  output logic [3*W-1:0]    core_z,
  output logic [5:0]        core_joint_type,
  output logic [6*W-1:0]    core_dh_in,
  output logic [6*W-1:0]    core_target
);
  typedef enum logic [2:0] {IDLE, CLR, RUN, CHECK, DONE} state_t;
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  state_t            state;
  logic [WD_W-1:0]   wd;
  logic [ITER_W-1:0] budget;
  logic [W-1:0]      tol;
  logic [W-1:0]      max_mag;
  logic [6*W-1:0]    delta;
  // the most negative value has no positive twin, so it saturates
  function automatic logic [W-1:0] mag(input logic [W-1:0] d);
    return d[W-1] ? (d[W-2:0] == '0 ? {1'b0, {(W-1){1'b1}}} : -d) : d;
  endfunction
  always_comb begin
    max_mag = '0;
    for (int i = 0; i < 6; i++)
      max_mag = mag(delta[i*W +: W]) > max_mag ? mag(delta[i*W +: W]) : max_mag;
  end
  assign core_dh_in = dh_result;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wd              <= '0;
      budget          <= '0;
      tol             <= '0;
      delta           <= '0;
      busy            <= 1'b0;
      result_valid    <= 1'b0;
      dh_result       <= '0;
      iter_count      <= '0;
      converged       <= 1'b0;
      timeout_err     <= 1'b0;
      core_en         <= 1'b0;
      core_rst        <= 1'b0;
      core_z          <= '0;
      core_joint_type <= '0;
      core_target     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          budget          <= cfg_max_iter == '0 ? ITER_W'(1) : cfg_max_iter;
          tol             <= cfg_tol;
          core_z          <= z_in;
          core_joint_type <= joint_type_in;
          dh_result       <= dh_init;
          core_target     <= target_in;
          iter_count      <= '0;
          converged       <= 1'b0;
          timeout_err     <= 1'b0;
          busy            <= 1'b1;
          core_rst        <= 1'b1;
          state           <= CLR;
        end
        CLR: begin
          core_rst <= 1'b0;
          core_en  <= 1'b1;
          wd       <= '0;
          state    <= RUN;
        end
        RUN: if (core_done) begin
          dh_result  <= core_dh_out;
          delta      <= core_delta;
          iter_count <= iter_count + 1'b1;
          core_en    <= 1'b0;
          state      <= CHECK;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          timeout_err  <= 1'b1;
          core_en      <= 1'b0;
          busy         <= 1'b0;
          result_valid <= 1'b1;
          state        <= DONE;
        end else begin
          wd <= wd + 1'b1;
        end
        CHECK: if (max_mag < tol || iter_count >= budget) begin
          converged    <= max_mag < tol;
          busy         <= 1'b0;
          result_valid <= 1'b1;
          state        <= DONE;
        end else begin
          core_rst <= 1'b1;
          state    <= CLR;
        end
        DONE: if (result_ack) begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ik_swift_iter_ctrl.sv
// tb_ik_swift_iter_ctrl: scoreboard bench with a stub core driving the iteration sequencer
module tb_ik_swift_iter_ctrl;
  localparam int W = 36;
  localparam int IW = 8;
  localparam int TO = 16;
  localparam int DW = 6*W;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic result_ack = 1'b0;
  logic [IW-1:0] cfg_max_iter = '0;
  logic [W-1:0] cfg_tol = '0;
  logic [3*W-1:0] z_in = '0;
  logic [5:0] joint_type_in = '0;
  logic [DW-1:0] dh_init = '0;
  logic [DW-1:0] target_in = '0;
  logic busy, result_valid, converged, timeout_err, core_en, core_rst, core_done;
  logic [DW-1:0] dh_result, core_delta, core_dh_out, core_dh_in, core_target;
  logic [IW-1:0] iter_count;
  logic [3*W-1:0] core_z;
  logic [5:0] core_joint_type;
  logic [DW-1:0] dtab [0:15];
  int npulse = 0;
  int cyc = 0;
  int base = 0;
  int hang = 0;
  int seed = 0;
  int total = 0;
  int bad = 0;
  logic [7:0] k;
  typedef struct {
    logic [DW-1:0] dh;
    logic [IW-1:0] it;
    logic cv;
    logic to;
  } exp_t;
  exp_t q[$];

  ik_swift_iter_ctrl #(.W(W), .ITER_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_max_iter(cfg_max_iter), .cfg_tol(cfg_tol),
    .z_in(z_in), .joint_type_in(joint_type_in), .dh_init(dh_init), .target_in(target_in),
    .busy(busy), .result_valid(result_valid), .result_ack(result_ack), .dh_result(dh_result),
    .iter_count(iter_count), .converged(converged), .timeout_err(timeout_err),
    .core_en(core_en), .core_rst(core_rst), .core_done(core_done), .core_delta(core_delta),
    .core_dh_out(core_dh_out), .core_z(core_z), .core_joint_type(core_joint_type),
    .core_dh_in(core_dh_in), .core_target(core_target)
  );

  always #5 clk = ~clk;

  // stub core: k is the iteration number of the current job, done on the third enabled cycle
  assign k = 8'(npulse - base);
  assign core_done = core_en && cyc == 2 && int'(k) != hang;
  assign core_delta = dtab[k[3:0]];
  assign core_dh_out = {6{W'(seed + int'(k))}};
  always @(posedge clk) begin
    if (core_rst) npulse <= npulse + 1;
    cyc <= core_rst ? 0 : core_en ? cyc + 1 : cyc;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [W-1:0] v, input int joint);
    for (int i = 0; i < 16; i++) dtab[i] = DW'(v) << (joint*W);
  endtask

  task automatic issue_job(input int bud, input logic [W-1:0] tol, input int sd,
                           input int e_it, input logic e_cv, input logic e_to, input int hg);
    cfg_max_iter = IW'(bud);
    cfg_tol = tol;
    seed = sd;
    hang = hg;
    base = npulse;
    dh_init = {6{W'(sd + 100)}};
    target_in = {6{W'($urandom)}};
    z_in = {3{W'($urandom)}};
    joint_type_in = 6'($urandom);
    if (e_it >= 0) q.push_back('{{6{W'(sd + e_it)}}, IW'(e_it), e_cv, e_to});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_pulse", DW'(core_rst), DW'(1));
    chk("busy_on", DW'(busy), DW'(1));
    chk("dh_latch", core_dh_in, dh_init);
    chk("cfg_latch", {core_target, core_z, core_joint_type}, {target_in, z_in, joint_type_in});
  endtask

  task automatic wait_rv();
    int n = 0;
    while (!result_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) chk("result_timeout", DW'(0), DW'(1));
  endtask

  task automatic finish_job(input int hold);
    logic [DW+IW+2:0] snap;
    logic stable = 1'b1;
    wait_rv();
    snap = {dh_result, iter_count, converged, timeout_err, result_valid};
    repeat (hold) begin
      @(negedge clk);
      if ({dh_result, iter_count, converged, timeout_err, result_valid} !== snap) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", DW'(stable), DW'(1));
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    chk("ack_clears", DW'(result_valid), DW'(0));
  endtask

  initial begin
    logic prv;
    prv = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid && !prv) begin
        if (q.size() == 0) chk("unexpected_result", DW'(1), DW'(0));
        else begin
          exp_t e;
          e = q.pop_front();
          chk("dh_result", dh_result, e.dh);
          chk("iter_count", DW'(iter_count), DW'(e.it));
          chk("converged", DW'(converged), DW'(e.cv));
          chk("timeout_err", DW'(timeout_err), DW'(e.to));
          chk("busy_off", DW'(busy), DW'(0));
        end
      end
      prv = result_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    fill('0, 0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_valid", DW'(result_valid), DW'(0));
    chk("rst_core", DW'({core_en, core_rst}), DW'(0));
    chk("rst_flags", DW'({converged, timeout_err}), DW'(0));
    chk("rst_iter", DW'(iter_count), DW'(0));
    chk("rst_dh", dh_result, '0);
    chk("rst_target", core_target, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // converge on iteration 3; a mid-job start with loose settings must be ignored
    fill('0, 0);
    dtab[1] = DW'('h100);
    dtab[2] = DW'('h40);
    dtab[3] = DW'('h8);
    issue_job(10, W'('h10), 1000, 3, 1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    cfg_max_iter = 8'd1;
    cfg_tol = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_job(20);
    chk("rst_pulses_conv", DW'(npulse - base), DW'(3));
    // budget exhaustion, then a zero budget meaning one iteration
    fill(W'('h1000), 0);
    issue_job(4, W'('h10), 2000, 4, 1'b0, 1'b0, 0);
    finish_job(1);
    issue_job(0, W'('h10), 3000, 1, 1'b0, 1'b0, 0);
    finish_job(0);
    chk("rst_pulses_b0", DW'(npulse - base), DW'(1));
    // zero tolerance never converges even with zero deltas
    fill('0, 0);
    issue_job(2, '0, 3500, 2, 1'b0, 1'b0, 0);
    finish_job(0);
    // most negative delta saturates to just below 2^35
    fill({1'b1, {(W-1){1'b0}}}, 3);
    issue_job(1, {1'b0, {(W-1){1'b1}}}, 4000, 1, 1'b0, 1'b0, 0);
    finish_job(0);
    fill(-W'(5), 5);
    issue_job(5, W'(6), 4500, 1, 1'b1, 1'b0, 0);
    finish_job(0);
    // core stalls on iteration 2
    fill(W'('h1000), 1);
    issue_job(5, W'('h10), 5000, 1, 1'b0, 1'b1, 2);
    wait_rv();
    chk("stall_en_cycles", DW'(cyc), DW'(TO));
    chk("stall_en_low", DW'(core_en), DW'(0));
    finish_job(0);
    // start together with ack is dropped; start on the following cycle is taken
    fill('0, 0);
    issue_job(5, W'(1), 6000, 1, 1'b1, 1'b0, 0);
    wait_rv();
    start = 1'b1;
    result_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    result_ack = 1'b0;
    chk("ack_start_drop", DW'({busy, result_valid}), DW'(0));
    issue_job(5, W'(1), 6500, 1, 1'b1, 1'b0, 0);
    finish_job(0);
    // asynchronous reset during iteration 2
    fill(W'('h1000), 2);
    issue_job(5, W'('h10), 7000, -1, 1'b0, 1'b0, 0);
    n = 0;
    while (!(k == 8'd2 && core_en) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_iter2", DW'(k == 8'd2 && core_en), DW'(1));
    rst_n = 1'b0;
    #1;
    chk("async_abort", DW'({core_en, busy, result_valid, core_rst}), DW'(0));
    chk("async_iter", DW'(iter_count), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill('0, 0);
    issue_job(3, W'(1), 8000, 1, 1'b1, 1'b0, 0);
    finish_job(0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", DW'(q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
